// File: rtl/merge_sort_stream.sv
// Streaming bottom-up merge sorter: loads a frame of up to N keys, pads the tail,
// runs LOG2N ping-pong merge passes between two banks, then drains the sorted keys.
module merge_sort_stream #(
   parameter int DW       = 32,
   parameter int LOG2N    = 4,
   parameter int KEY_MODE = 2
) (
   input  logic          clk,
   input  logic          res,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic          descending,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy
);

   localparam int N  = 1 << LOG2N;
   localparam int AW = LOG2N;
   localparam int CW = LOG2N + 1;
   localparam logic [CW-1:0] N_C       = CW'(N);
   localparam logic [CW-1:0] LAST_PASS = CW'(LOG2N - 1);
   localparam logic [DW-1:0] MSB       = {1'b1, {(DW-1){1'b0}}};
   localparam bit RESULT_IN_B = (LOG2N % 2) == 1;

   // Maps a key onto an unsigned-comparable code; stored data is never altered.
   function automatic logic [DW-1:0] key_xf(input logic [DW-1:0] v);
      if (KEY_MODE == 0) return v;
      else if (KEY_MODE == 1) return v ^ MSB;
      else return v[DW-1] ? ~v : (v ^ MSB);
   endfunction

   function automatic logic [DW-1:0] key_inv(input logic [DW-1:0] t);
      if (KEY_MODE == 0) return t;
      else if (KEY_MODE == 1) return t ^ MSB;
      else return t[DW-1] ? (t ^ MSB) : ~t;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PAD,
      S_MERGE,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] pass_q, pass_d;
   logic [CW-1:0] li_q, li_d;
   logic [CW-1:0] ri_q, ri_d;
   logic          desc_q, desc_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;
   logic [DW-1:0] out_data_q, out_data_d;

   logic [DW-1:0] bank_a [N];
   logic [DW-1:0] bank_b [N];
   logic          a_we, b_we;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic [CW-1:0] w, two_w, base;
   logic [AW-1:0] l_addr, r_addr;
   logic [DW-1:0] l_val, r_val, res_val, kl, kr, sentinel;
   logic          take_left;

   // The output slot cnt_q determines which pair of runs is being merged.
   assign w       = CW'(1) << pass_q;
   assign two_w   = w << 1;
   assign base    = cnt_q & ~(two_w - CW'(1));
   assign l_addr  = AW'(base + li_q);
   assign r_addr  = AW'(base + w + ri_q);
   assign l_val   = pass_q[0] ? bank_b[l_addr] : bank_a[l_addr];
   assign r_val   = pass_q[0] ? bank_b[r_addr] : bank_a[r_addr];
   assign res_val = RESULT_IN_B ? bank_b[AW'(cnt_q)] : bank_a[AW'(cnt_q)];

   // Ties take the left run so the merge is stable and tail pads stay behind real keys.
   always_comb begin
      kl        = key_xf(l_val);
      kr        = key_xf(r_val);
      take_left = (ri_q == w) || ((li_q != w) && (desc_q ? (kl >= kr) : (kl <= kr)));
      sentinel  = desc_q ? key_inv('0) : key_inv('1);
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      li_d        = li_q;
      ri_d        = ri_q;
      desc_d      = desc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      a_we        = 1'b0;
      b_we        = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_we    = 1'b1;
               wr_addr = '0;
               wr_data = in_data;
               desc_d  = descending;
               len_d   = CW'(1);
               cnt_d   = CW'(1);
               if (in_last) begin
                  state_d    = S_PAD;
                  in_ready_d = 1'b0;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               a_we    = 1'b1;
               wr_addr = AW'(len_q);
               wr_data = in_data;
               len_d   = len_q + CW'(1);
               cnt_d   = len_q + CW'(1);
               if (len_q + CW'(1) == N_C) begin
                  state_d    = S_MERGE;
                  in_ready_d = 1'b0;
                  cnt_d      = '0;
                  pass_d     = '0;
                  li_d       = '0;
                  ri_d       = '0;
               end else if (in_last) begin
                  state_d    = S_PAD;
                  in_ready_d = 1'b0;
               end
            end
         end
         S_PAD: begin
            a_we    = 1'b1;
            wr_addr = AW'(cnt_q);
            wr_data = sentinel;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == N_C - CW'(1)) begin
               state_d = S_MERGE;
               cnt_d   = '0;
               pass_d  = '0;
               li_d    = '0;
               ri_d    = '0;
            end
         end
         S_MERGE: begin
            a_we    = pass_q[0];
            b_we    = !pass_q[0];
            wr_addr = AW'(cnt_q);
            wr_data = take_left ? l_val : r_val;
            if (take_left) li_d = li_q + CW'(1);
            else           ri_d = ri_q + CW'(1);
            if (li_q + ri_q + CW'(1) == two_w) begin
               li_d = '0;
               ri_d = '0;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == N_C - CW'(1)) begin
               cnt_d  = '0;
               pass_d = pass_q + CW'(1);
               if (pass_q == LAST_PASS) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = res_val;
               out_last_d  = (len_q == CW'(1));
               cnt_d       = CW'(1);
            end else if (out_ready) begin
               if (out_last_q) begin
                  state_d     = S_IDLE;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  len_d       = '0;
                  cnt_d       = '0;
               end else begin
                  out_data_d = res_val;
                  out_last_d = (cnt_q == len_q - CW'(1));
                  cnt_d      = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         pass_q      <= '0;
         li_q        <= '0;
         ri_q        <= '0;
         desc_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         pass_q      <= pass_d;
         li_q        <= li_d;
         ri_q        <= ri_d;
         desc_q      <= desc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (a_we) bank_a[wr_addr] <= wr_data;
      if (b_we) bank_b[wr_addr] <= wr_data;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_merge_sort_stream.sv
// Bench for merge_sort_stream: a float-key 16-deep sorter and a two's complement 8-deep
// sorter, checked against a stable insertion-sort reference on numeric key order.
module tb_merge_sort_stream;

   logic        clk = 1'b0;
   logic        res, in_valid, in_last, descending, out_ready, sel;
   logic [31:0] in_data;

   logic        in_ready0, out_valid0, out_last0, busy0;
   logic [31:0] out_data0;
   logic        in_ready1, out_valid1, out_last1, busy1;
   logic [31:0] out_data1;

   logic        in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [31:0] out_data_m;

   always #5 clk = ~clk;

   merge_sort_stream #(.DW(32), .LOG2N(4), .KEY_MODE(2)) dut (
      .clk(clk), .res(res),
      .in_valid(in_valid && !sel), .in_ready(in_ready0), .in_data(in_data),
      .in_last(in_last), .descending(descending),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_last(out_last0), .busy(busy0)
   );

   merge_sort_stream #(.DW(32), .LOG2N(3), .KEY_MODE(1)) dut_tc (
      .clk(clk), .res(res),
      .in_valid(in_valid && sel), .in_ready(in_ready1), .in_data(in_data),
      .in_last(in_last), .descending(descending),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_last(out_last1), .busy(busy1)
   );

   assign in_ready_m  = sel ? in_ready1  : in_ready0;
   assign out_valid_m = sel ? out_valid1 : out_valid0;
   assign out_last_m  = sel ? out_last1  : out_last0;
   assign out_data_m  = sel ? out_data1  : out_data0;
   assign busy_m      = sel ? busy1      : busy0;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   int last_hs = 0;
   logic [31:0] frame_q[$];
   logic [31:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Numeric rank of a key: unsigned, signed, or float order with -0 just below +0.
   function automatic longint rankOf(input int mode, input logic [31:0] v);
      if (mode == 0) return longint'({32'b0, v});
      if (mode == 1) return longint'($signed(v));
      if (v[31]) return -longint'({33'b0, v[30:0]}) - 1;
      return longint'({33'b0, v[30:0]});
   endfunction

   function automatic void buildExpected(input int mode, input logic desc);
      exp_q.delete();
      foreach (frame_q[i]) begin
         int pos;
         longint rx;
         rx  = rankOf(mode, frame_q[i]);
         pos = exp_q.size();
         for (int j = 0; j < exp_q.size(); j++) begin
            if (desc ? (rx > rankOf(mode, exp_q[j])) : (rx < rankOf(mode, exp_q[j]))) begin
               pos = j;
               break;
            end
         end
         exp_q.insert(pos, frame_q[i]);
      end
   endfunction

   // Later words carry the opposite order bit: only the first word's value may count.
   task automatic applyStimulus(input logic desc, input bit gaps);
      for (int i = 0; i < frame_q.size(); i++) begin
         int guard;
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         in_valid   = 1'b1;
         in_data    = frame_q[i];
         in_last    = (i == frame_q.size() - 1);
         descending = (i == 0) ? desc : ~desc;
         guard = 0;
         while (!in_ready_m && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) begin
            checkOutput("in_ready_wait", 64'd0, 64'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      last_hs = cyc;
   endtask

   // ready_mode: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random.
   task automatic collect(input int ready_mode, input int lat_exp);
      int  k, guard, pidx, len;
      bit  seen, stall;
      logic [31:0] held_d;
      logic        held_l;
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      len = exp_q.size();
      k = 0; guard = 0; pidx = 0; seen = 0; stall = 0;
      held_d = '0; held_l = 1'b0;
      while (k < len && guard < 3000) begin
         if (out_valid_m) begin
            if (!seen) begin
               seen = 1;
               checkOutput("latency", 64'(cyc - last_hs), 64'(lat_exp));
               checkOutput("in_ready_drain", 64'(in_ready_m), 64'd0);
               checkOutput("busy_drain", 64'(busy_m), 64'd1);
            end
            if (stall) begin
               checkOutput("hold_data", 64'(out_data_m), 64'(held_d));
               checkOutput("hold_last", 64'(out_last_m), 64'(held_l));
            end
         end else if (stall) begin
            checkOutput("valid_drop", 64'd0, 64'd1);
         end
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = out_valid_m ? pat[pidx % 4] : 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid_m) pidx++;
         if (out_valid_m && out_ready) begin
            checkOutput("data", 64'(out_data_m), 64'(exp_q[k]));
            checkOutput("last", 64'(out_last_m), 64'(k == len - 1));
            k++;
         end
         stall  = out_valid_m && !out_ready;
         held_d = out_data_m;
         held_l = out_last_m;
         @(negedge clk);
         guard++;
      end
      if (k < len) begin
         checkOutput("drain_timeout", 64'(k), 64'(len));
      end else begin
         checkOutput("post_valid", 64'(out_valid_m), 64'd0);
         checkOutput("post_in_ready", 64'(in_ready_m), 64'd1);
         checkOutput("post_busy", 64'(busy_m), 64'd0);
      end
      out_ready = 1'b0;
   endtask

   task automatic runFrame(input int mode, input logic desc, input bit gaps, input int ready_mode);
      int n, lg;
      n  = sel ? 8 : 16;
      lg = sel ? 3 : 4;
      buildExpected(mode, desc);
      applyStimulus(desc, gaps);
      collect(ready_mode, (n - frame_q.size()) + lg * n + 1);
   endtask

   function automatic void randomFrame(input int mode, input int n);
      frame_q.delete();
      for (int i = 0; i < n; i++) begin
         logic [31:0] v;
         int r;
         r = $urandom_range(0, 7);
         if (mode == 1) begin
            v = (r < 5) ? 32'($signed($urandom_range(0, 15)) - 8) : 32'($urandom);
         end else begin
            case (r)
               0:       v = 32'h0000_0000;
               1:       v = 32'h8000_0000;
               2:       v = 32'h7F80_0000;
               3:       v = 32'hFF80_0000;
               4:       v = 32'h7FC0_0000;
               default: v = 32'($urandom);
            endcase
         end
         if (i > 0 && $urandom_range(0, 5) == 0) v = frame_q[i-1];
         frame_q.push_back(v);
      end
   endfunction

   initial begin
      res = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      descending = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", 64'(in_ready0), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid0), 64'd0);
      checkOutput("rst_out_last", 64'(out_last0), 64'd0);
      checkOutput("rst_out_data", 64'(out_data0), 64'd0);
      checkOutput("rst_busy", 64'(busy0), 64'd0);
      checkOutput("rst_busy_tc", 64'(busy1), 64'd0);
      res = 1'b0;
      @(negedge clk);

      $display("[TB] float ascending 16 words");
      frame_q = '{32'h40400000, 32'hBFC00000, 32'h00000000, 32'h80000000,
                  32'h40E80000, 32'hC1000000, 32'h3F800000, 32'h40000000,
                  32'hC0000000, 32'h3F000000, 32'h42C80000, 32'hC2C80000,
                  32'h40800000, 32'h3E800000, 32'hBE800000, 32'h41100000};
      runFrame(2, 1'b0, 1'b0, 0);

      $display("[TB] short frame of 5");
      frame_q = '{32'h40400000, 32'hBF800000, 32'h7F7FFFFF, 32'h00000000, 32'h3F800000};
      runFrame(2, 1'b0, 1'b1, 0);

      $display("[TB] two's complement descending");
      sel = 1'b1;
      @(negedge clk);
      frame_q = '{32'd5, -32'sd3, 32'd0, 32'd127, -32'sd128, 32'd5, 32'd1, -32'sd1};
      runFrame(1, 1'b1, 1'b0, 0);
      sel = 1'b0;
      @(negedge clk);

      $display("[TB] backpressure 1-0-0-1");
      randomFrame(2, 11);
      runFrame(2, 1'b1, 1'b0, 1);

      $display("[TB] reset during merge");
      randomFrame(2, 16);
      applyStimulus(1'b0, 1'b0);
      repeat (20) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 64'(busy0), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready0), 64'd1);
      checkOutput("abort_out_valid", 64'(out_valid0), 64'd0);
      res = 1'b0;
      @(negedge clk);
      frame_q = '{32'h40400000, 32'hBFC00000, 32'h00000000, 32'h80000000,
                  32'h40E80000, 32'hC1000000, 32'h3F800000, 32'h40000000,
                  32'hC0000000, 32'h3F000000, 32'h42C80000, 32'hC2C80000,
                  32'h40800000, 32'h3E800000, 32'hBE800000, 32'h41100000};
      runFrame(2, 1'b1, 1'b0, 2);

      $display("[TB] single-word frame");
      frame_q = '{32'hDEADBEEF};
      runFrame(2, 1'b0, 1'b0, 0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 8; f++) begin
         randomFrame(2, $urandom_range(1, 16));
         runFrame(2, 1'($urandom_range(0, 1)), 1'b1, 2);
      end
      sel = 1'b1;
      @(negedge clk);
      for (int f = 0; f < 6; f++) begin
         randomFrame(1, $urandom_range(1, 8));
         runFrame(1, 1'($urandom_range(0, 1)), 1'b1, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/merge_sort_stream.md
Name: merge_sort_stream

Overview:
- Parametrised bottom-up merge sorter for frames of up to N keys.
- Frames arrive over a valid/ready stream and leave over a valid/ready stream in sorted order.
- Generalises the fixed 16×32-bit float sorter:
  - configurable data width and depth;
  - three key modes: unsigned, two's complement, IEEE-754 sign-magnitude;
  - per-frame ascending/descending order;
  - short frames;
  - output backpressure.

Parameters:
- DW, 32: key/data width in bits (≥2).
- LOG2N, 4: log2 of maximum frame depth; N = 2^LOG2N (N ≥ 2).
- KEY_MODE, 2: 0 = unsigned, 1 = two's complement, 2 = IEEE-754 sign-magnitude.

Ports:
- clk, input, 1: sole clock, rising edge.
- res, input, 1: synchronous active-high reset.
- in_valid, input, 1: input word valid.
- in_ready, output, 1: sorter accepting input.
- in_data, input, DW: input key.
- in_last, input, 1: final word of frame.
- descending, input, 1: order select, sampled with the first word of a frame.
- out_valid, output, 1: output word valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DW: sorted key.
- out_last, output, 1: final word of sorted frame.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Interface: one clock `clk`; reset `res` is synchronous and active-high.
- Reset: state = IDLE; in_ready = 1; out_valid = 0, out_last = 0, out_data = 0, busy = 0. Counters and len clear.
- A reset asserted in any state aborts the frame. Partial data is discarded and no output is produced.
- Key transform, applied only for comparison; stored data is unchanged:
  - mode 0: identity;
  - mode 1: invert MSB;
  - mode 2: if MSB = 1 invert all bits, else invert MSB.
- After the transform, keys compare as unsigned. Consequences for mode 2: -0 orders before +0, and NaNs order by bit pattern.
- Descending mode inverts the comparison result.
- Ties take from the left run, so the sort is stable.

State machine:
- IDLE:
  - in_ready = 1.
  - On an accepted word (in_valid & in_ready): write bank A[0], latch descending, set len = 1, go to LOAD.
  - If in_last is also high, go straight to PAD.
- LOAD:
  - in_ready = 1; each accepted word writes A[len] and increments len.
  - Go to PAD on an accepted word with in_last, or when len reaches N. A word at len = N ends the frame whether or not in_last is set.
  - in_valid low holds the state with no timeout.
- PAD:
  - in_ready = 0.
  - One cycle per slot: write the sentinel into A[len..N-1]. Sentinel is maximum transformed key for ascending, minimum for descending.
  - Zero cycles when len = N.
  - Stability guarantees the tail pads never precede real keys, including real keys equal to the sentinel.
- MERGE:
  - LOG2N passes with run width w = 1, 2, …, N/2.
  - Ping-pong A→B, B→A.
  - Exactly one element is written per cycle, so each pass takes N cycles.
  - When one run is exhausted, the other run is copied.
  - After the final pass, the result bank is A if LOG2N is even, B if odd.
- DRAIN:
  - Present result[k] for k = 0..len-1; out_valid = 1.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_last = 1 only at k = len-1.
  - Pads are never output.
  - After the handshake on the last word, go to IDLE; in_ready rises the following cycle.

Timing and handshake rules:
- Latency from the last input handshake to the first out_valid: (N - len) + LOG2N·N + 1 cycles.
- in_ready is 0 in PAD, MERGE and DRAIN, so a new frame cannot overlap draining.
- out_valid never drops without a handshake, except on reset.
- A single-word frame (first word carries in_last) is legal: len = 1, and one word is output with out_last = 1.

Test Plan:
- Float, ascending, 16 words: {3.0, -1.5, 0.0, -0.0, 7.25, -8.0, 1.0, 2.0, -2.0, 0.5, 100.0, -100.0, 4.0, 0.25, -0.25, 9.0} → out -100, -8, -2, -1.5, -0.25, -0.0, 0.0, 0.25, 0.5, 1, 2, 3, 4, 7.25, 9, 100. out_last on the 16th word; first out_valid 65 cycles after the last input handshake.
- Short frame: 5 words {0x40400000, 0xBF800000, 0x7F7FFFFF, 0x00000000, 0x3F800000} with in_last on the 5th → exactly 5 outputs {0xBF800000, 0x00000000, 0x3F800000, 0x40400000, 0x7F7FFFFF}; no pad emitted; busy returns to 0.
- KEY_MODE=1, descending = 1: {5, -3, 0, 127, -128, 5, 1, -1} with in_last on the 8th → 127, 5, 5, 1, 0, -1, -3, -128.
- Backpressure: out_ready toggles 1-0-0-1 during DRAIN → out_data and out_last are held while stalled; no word is lost or duplicated; in_ready stays 0 until after the final handshake.
- Reset mid-MERGE: assert res for 1 cycle → next cycle busy = 0, in_ready = 1, out_valid = 0. A subsequent 16-word frame then sorts correctly with no residue from the aborted frame.
- Single-word frame: in_data = 0xDEADBEEF with in_last on the first word → one output 0xDEADBEEF with out_last = 1.
